// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide share one 2*XLEN working register.
// Operands are reduced to magnitudes on accept, and the sign is fixed up at the end.
// Divide-by-zero and signed overflow skip the iteration entirely.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            is_m,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0]   ONE_X    = XLEN'(1);
  localparam logic [2*XLEN-1:0] ONE_2X   = (2*XLEN)'(1);
  localparam logic [XLEN-1:0]   MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_f3;
  logic [2*XLEN-1:0] r_acc;     // mul: {product hi, multiplier/lo}; div: {remainder, quotient}
  logic [XLEN-1:0]   r_b;       // multiplicand or divisor magnitude
  logic              r_neg;     // negate product / quotient
  logic              r_neg_rem; // negate remainder
  logic [XLEN-1:0]   r_result;

  // Decode
  logic [2:0]      w_f3;
  logic            w_accept;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_result;
  logic            w_unused_bits;

  assign w_f3          = instruction[14:12];
  assign is_m          = (instruction[6:0] == 7'b0110011) && (instruction[31:25] == 7'b0000001);
  assign in_ready      = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign out_valid     = (r_state == S_DONE);
  assign result        = r_result;
  assign w_accept      = in_valid && in_ready && is_m && !flush;
  assign w_unused_bits = ^{instruction[24:15], instruction[11:7]};

  // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed
  assign w_a_signed = (w_f3 == 3'b001) || (w_f3 == 3'b010) || (w_f3 == 3'b100) || (w_f3 == 3'b110);
  assign w_b_signed = (w_f3 == 3'b001) || (w_f3 == 3'b100) || (w_f3 == 3'b110);
  assign w_sa       = w_a_signed && op_a[XLEN-1];
  assign w_sb       = w_b_signed && op_b[XLEN-1];
  assign w_mag_a    = w_sa ? (~op_a + ONE_X) : op_a;
  assign w_mag_b    = w_sb ? (~op_b + ONE_X) : op_b;

  assign w_div_zero = (op_b == '0);
  assign w_ovf      = !w_f3[0] && (op_a == MOST_NEG) && (op_b == '1);
  assign w_special  = w_f3[2] && (w_div_zero || w_ovf);

  // Divide-by-zero takes priority: REM gives the dividend, DIV gives all-ones
  always_comb begin
    w_special_result = '0;
    if (w_div_zero)
      w_special_result = w_f3[1] ? op_a : '1;
    else
      w_special_result = w_f3[1] ? '0 : MOST_NEG;
  end

  // Multiply step: conditional add into the high half, then shift right with carry
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_b};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};

  // Restoring divide step: shift in next dividend bit, keep the difference when it does not borrow
  logic [XLEN:0]     w_div_shift;
  logic [XLEN:0]     w_div_diff;
  logic [2*XLEN-1:0] w_div_next;
  assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_div_next  = w_div_diff[XLEN] ? {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                        : {w_div_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};

  // Sign correction and result selection once the iterations are complete
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;
  assign w_prod = r_neg ? (~r_acc + ONE_2X) : r_acc;
  assign w_quo  = r_neg ? (~r_acc[XLEN-1:0] + ONE_X) : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_rem ? (~r_acc[2*XLEN-1:XLEN] + ONE_X) : r_acc[2*XLEN-1:XLEN];

  // Pick the rd value for the latched funct3
  always_comb begin
    w_final = '0;
    case (r_f3)
      3'b000:                 w_final = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = w_quo;
      default:                w_final = w_rem;
    endcase
  end

  // Control FSM and datapath. CALC runs XLEN iteration cycles, then one more
  // cycle applies the sign correction and enters DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_f3      <= '0;
      r_acc     <= '0;
      r_b       <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_f3      <= w_f3;
            r_acc     <= {{XLEN{1'b0}}, w_mag_a};
            r_b       <= w_mag_b;
            r_neg     <= w_sa ^ w_sb;
            r_neg_rem <= w_sa;
            r_cnt     <= '0;
            if (w_special) begin
              r_result <= w_special_result;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (r_cnt == CW'(XLEN)) begin
            r_result <= w_final;
            r_state  <= S_DONE;
          end else begin
            r_acc <= r_f3[2] ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
